// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyser frame scheduler.
package la_pkg;
  localparam int NUM_CH       = 8;
  localparam int BYTE_W       = 8;
  localparam int LEN_W        = 4;
  localparam int DEF_SLOT_LEN = 15;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    SLOT
  } state_e;
endpackage

// File: rtl/la_next_chan.sv
// Combinational finder: lowest set mask bit strictly above the given index.
module la_next_chan #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 3
) (
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [NUM_CH-1:0] i_mask,
  output logic [IDX_W-1:0]  o_next,
  output logic              o_found
);
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!o_found && i_mask[k] && (k > 32'(i_idx))) begin
        o_next  = IDX_W'(k);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/la_frame_scheduler.sv
// Snapshots probe bytes and plays enabled channels onto Dout, one slot each,
// as single or continuous sweeps.
module la_frame_scheduler #(
  parameter int NUM_CH = la_pkg::NUM_CH,
  parameter int LEN_W  = la_pkg::LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                single,
  input  logic [NUM_CH-1:0]   chan_mask,
  input  logic [LEN_W-1:0]    slot_len,
  input  logic [8*NUM_CH-1:0] probe_in,
  output logic [7:0]          Dout,
  output logic                trigger,
  output logic [2:0]          slot_idx,
  output logic                busy,
  output logic                sweep_done
);
  import la_pkg::*;

  localparam int IDX_W = 3;

  state_e                          r_state;
  logic                            r_pend;
  logic [LEN_W-1:0]                r_cnt;
  logic [LEN_W-1:0]                r_len;
  logic [NUM_CH-1:0]               r_mask;
  logic [NUM_CH-1:0][BYTE_W-1:0]   r_snap;
  logic [IDX_W-1:0]                r_idx;
  logic [BYTE_W-1:0]               r_dout;
  logic                            r_trig;
  logic                            r_busy;
  logic                            r_done;

  logic [NUM_CH-1:0][BYTE_W-1:0]   w_probe;
  logic                            w_in_snap;
  logic                            w_req;
  logic [IDX_W-1:0]                w_a_idx;
  logic [NUM_CH-1:0]               w_a_mask;
  logic [IDX_W-1:0]                w_a_next;
  logic                            w_a_found;
  logic [IDX_W-1:0]                w_first;
  logic [IDX_W-1:0]                w_b_idx;
  logic [IDX_W-1:0]                w_b_next;
  logic                            w_b_found;

  assign w_probe   = probe_in;
  assign w_in_snap = (r_state == SNAP);
  assign w_req     = (enable | r_pend) & (|chan_mask);

  // Finder A: successor of the current slot (or of bit 0 while snapping).
  // Finder B: successor of the channel about to be loaded, so sweep_done can
  // be registered one cycle ahead of the final slot cycle.
  assign w_a_idx  = w_in_snap ? '0 : r_idx;
  assign w_a_mask = w_in_snap ? chan_mask : r_mask;
  assign w_first  = chan_mask[0] ? '0 : w_a_next;
  assign w_b_idx  = w_in_snap ? w_first : w_a_next;

  la_next_chan #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_next_a (
    .i_idx   (w_a_idx),
    .i_mask  (w_a_mask),
    .o_next  (w_a_next),
    .o_found (w_a_found)
  );

  la_next_chan #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_next_b (
    .i_idx   (w_b_idx),
    .i_mask  (w_a_mask),
    .o_next  (w_b_next),
    .o_found (w_b_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mask  <= '0;
      r_snap  <= '0;
      r_idx   <= '0;
      r_dout  <= '0;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= r_pend | single;
      case (r_state)
        IDLE: begin
          r_trig <= 1'b0;
          if (w_req) begin
            r_state <= SNAP;
            r_busy  <= 1'b1;
            r_pend  <= single;
          end else if (chan_mask == '0) begin
            r_pend <= single;
          end
        end
        SNAP: begin
          if (|chan_mask) begin
            r_state <= SLOT;
            r_snap  <= w_probe;
            r_mask  <= chan_mask;
            r_len   <= slot_len;
            r_idx   <= w_first;
            r_dout  <= w_probe[w_first];
            r_trig  <= 1'b1;
            r_cnt   <= '0;
            r_done  <= (slot_len == '0) && !w_b_found;
          end else begin
            // Mask dropped to zero during the snapshot cycle: nothing to play.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SLOT: begin
          if (r_cnt != r_len) begin
            r_cnt  <= r_cnt + 1'b1;
            r_done <= (LEN_W'(r_cnt + 1'b1) == r_len) && !w_a_found;
          end else if (w_a_found) begin
            r_idx  <= w_a_next;
            r_dout <= r_snap[w_a_next];
            r_trig <= 1'b0;
            r_cnt  <= '0;
            r_done <= (r_len == '0) && !w_b_found;
          end else begin
            r_trig <= 1'b0;
            r_cnt  <= '0;
            if (w_req) begin
              r_state <= SNAP;
              r_pend  <= single;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Dout       = r_dout;
  assign trigger    = r_trig;
  assign slot_idx   = r_idx;
  assign busy       = r_busy;
  assign sweep_done = r_done;
endmodule

// File: tb/tb_la_frame_scheduler.sv
// Bench for la_frame_scheduler: directed scenarios plus random traffic checked
// against a sweep-queue reference model.
module tb_la_frame_scheduler;
  localparam int NCH = 8;
  localparam int LW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            single = 1'b0;
  logic [NCH-1:0]  chan_mask = '0;
  logic [LW-1:0]   slot_len = '0;
  logic [8*NCH-1:0] probe_in = '0;
  logic [7:0]      Dout;
  logic            trigger;
  logic [2:0]      slot_idx;
  logic            busy;
  logic            sweep_done;

  la_frame_scheduler #(.NUM_CH(NCH), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .single     (single),
    .chan_mask  (chan_mask),
    .slot_len   (slot_len),
    .probe_in   (probe_in),
    .Dout       (Dout),
    .trigger    (trigger),
    .slot_idx   (slot_idx),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sweep is a precomputed list of per-cycle outputs.
  typedef struct packed {
    logic [7:0] d;
    logic [2:0] idx;
    logic       trig;
    logic       done;
  } item_t;

  item_t q[$];
  item_t cur;
  int    ph;      // 0 idle, 1 snapshot cycle, 2 playing a sweep
  bit    m_pend;

  function automatic void build_sweep();
    item_t it;
    bit    first = 1'b1;
    logic [7:0] pb;
    q.delete();
    for (int k = 0; k < NCH; k++) begin
      if (chan_mask[k]) begin
        pb = probe_in[8*k +: 8];
        for (int c = 0; c <= int'(slot_len); c++) begin
          it.d = pb; it.idx = 3'(k); it.trig = first; it.done = 1'b0;
          q.push_back(it);
        end
        first = 1'b0;
      end
    end
    q[q.size()-1].done = 1'b1;
  endfunction

  function automatic void model_reset();
    ph = 0; m_pend = 1'b0; cur = '0; q.delete();
  endfunction

  function automatic void model_step();
    bit req, np;
    if (rst) begin
      model_reset();
      return;
    end
    req = (enable || m_pend) && (chan_mask != 0);
    np  = single || m_pend;
    case (ph)
      0: if (req) begin ph = 1; np = single; end
         else if (chan_mask == 0) np = single;
      1: if (chan_mask != 0) begin build_sweep(); cur = q.pop_front(); ph = 2; end
         else ph = 0;
      default: if (q.size() == 0) begin
                 if (req) begin ph = 1; np = single; end else ph = 0;
               end else cur = q.pop_front();
    endcase
    m_pend = np;
  endfunction

  int cyc = 0, last_done = -1, period = 0, done_cnt = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (sweep_done === 1'b1) begin
      if (last_done >= 0) period = cyc - last_done;
      last_done = cyc;
      done_cnt++;
    end
    check_val("dout", 32'(Dout), 32'(cur.d));
    check_val("busy", 32'(busy), 32'(ph != 0));
    check_val("trigger", 32'(trigger), 32'(ph == 2 && cur.trig));
    check_val("sweep_done", 32'(sweep_done), 32'(ph == 2 && cur.done));
    if (ph == 2) check_val("slot_idx", 32'(slot_idx), 32'(cur.idx));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && ph != 0; i++) tick();
    check_val("reached_idle", 32'(busy), 32'(0));
  endtask

  task automatic set_probe_seq(input logic [7:0] base);
    for (int k = 0; k < NCH; k++) probe_in[8*k +: 8] = base + 8'(k);
  endtask

  initial begin
    int d0;
    model_reset();
    // Reset state
    ticks(2);
    check_val("rst_dout", 32'(Dout), 32'h00);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_idx", 32'(slot_idx), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Full mask, default slot length, continuous run; period measurement
    set_probe_seq(8'h10);
    chan_mask = 8'hFF; slot_len = LW'(la_pkg::DEF_SLOT_LEN); enable = 1'b1;
    tick();
    check_val("latency_snap_busy", 32'(busy), 32'h1);
    tick();
    check_val("first_dout", 32'(Dout), 32'h10);
    check_val("first_trig", 32'(trigger), 32'h1);
    ticks(2 * 129 + 4);
    check_val("period", 32'(period), 32'd129);

    // Mask 0x81, zero slot length, single pulse
    enable = 1'b0;
    wait_idle();
    chan_mask = 8'h81; slot_len = '0;
    single = 1'b1; tick(); single = 1'b0;
    ticks(6);

    // Probe change during slot 2 must wait for next snapshot
    chan_mask = 8'hFF; slot_len = 4'd3; enable = 1'b1;
    ticks(12);
    set_probe_seq(8'hA0);
    ticks(80);
    enable = 1'b0;
    wait_idle();

    // Two single pulses during a sweep collapse into one extra sweep
    d0 = done_cnt;
    enable = 1'b1; tick(); enable = 1'b0;
    ticks(4); single = 1'b1; tick(); single = 1'b0;
    ticks(4); single = 1'b1; tick(); single = 1'b0;
    ticks(100);
    check_val("collapse_sweeps", 32'(done_cnt - d0), 32'd2);
    check_val("collapse_idle", 32'(busy), 32'h0);

    // Mask zero with enable held
    chan_mask = '0; enable = 1'b1;
    ticks(20);
    check_val("mask0_busy", 32'(busy), 32'h0);

    // Mask shrinks mid-sweep
    chan_mask = 8'hFF; slot_len = 4'd1;
    ticks(6);
    chan_mask = 8'h0F;
    ticks(40);
    enable = 1'b0;
    wait_idle();

    // Asynchronous reset during slot 3
    chan_mask = 8'hFF; slot_len = 4'd2; enable = 1'b1;
    for (int i = 0; i < 100 && !(ph == 2 && cur.idx == 3'd3); i++) tick();
    check_val("reached_slot3", 32'(slot_idx), 32'd3);
    d0 = done_cnt;
    enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("async_dout", 32'(Dout), 32'h00);
    check_val("async_busy", 32'(busy), 32'h0);
    check_val("async_trig", 32'(trigger), 32'h0);
    tick();
    rst = 1'b0;
    ticks(5);
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
    enable = 1'b1;
    tick();
    check_val("post_rst_snap", 32'(busy), 32'h1);
    tick();
    check_val("post_rst_trig", 32'(trigger), 32'h1);
    enable = 1'b0;
    wait_idle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      single = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0)
        chan_mask = ($urandom_range(0, 7) == 0) ? '0 : NCH'($urandom);
      if ($urandom_range(0, 59) == 0) slot_len = LW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) probe_in = {$urandom, $urandom};
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; single = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
